// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller with blanking gaps,
// leading-zero suppression and per-digit masking over a shared decoder bus.
module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    input  logic [DIGITS-1:0]         blank_mask,
    input  logic                      lz_en,
    output logic [3:0]                bcd,
    output logic [DIGITS-1:0]         digit_an,
    output logic                      frame_tick
);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES);
    localparam logic [IW:0]   NDIG   = DIGITS[IW:0];
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] P_TICK = CW'(PRESCALE - 2);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [3:0]        regs_q [DIGITS];
    logic [3:0]        bcd_q;
    logic [DIGITS-1:0] an_q;
    logic              tick_q;
    logic [DIGITS-1:0] zero_from;
    logic              all_z;
    logic              sup_d;

    // zero_from[i] is set when every digit at or above i holds zero
    always_comb begin
        zero_from = '0;
        all_z = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_z = all_z && (regs_q[i] == 4'h0);
            zero_from[i] = all_z;
        end
        sup_d = blank_mask[idx_q] | (lz_en && idx_q != '0 && zero_from[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) regs_q[i] <= 4'h0;
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= 4'h0;
            an_q    <= '1;
            tick_q  <= 1'b0;
        end else begin
            if (wr_en && {1'b0, wr_addr} < NDIG) regs_q[wr_addr] <= wr_data;
            tick_q <= 1'b0;
            if (!en) begin
                state_q <= BLANK;
                cnt_q   <= '0;
                idx_q   <= '0;
                an_q    <= '1;
            end else if (state_q == BLANK) begin
                if (cnt_q == B_LAST) begin
                    state_q <= SHOW;
                    cnt_q   <= '0;
                    bcd_q   <= regs_q[idx_q];
                    an_q    <= sup_d ? '1 : ~(DIGITS'(1) << idx_q);
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                // raised one edge early so the pulse lands on the last SHOW cycle of the frame
                tick_q <= (idx_q == I_LAST) && (cnt_q == P_TICK);
                if (cnt_q == P_LAST) begin
                    state_q <= BLANK;
                    cnt_q   <= '0;
                    an_q    <= '1;
                    idx_q   <= (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bcd        = bcd_q;
    assign digit_an   = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench; a frame-position model predicts each cycle's
// outputs at the rising edge and the negedge monitor compares them.
module tb_seg_scan_ctrl;
    localparam int SLOT  = 6;
    localparam int BLNK  = 2;
    localparam int FRAME = 24;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [3:0] blank_mask = '0;
    logic       lz_en = 1'b0;
    logic [3:0] bcd;
    logic [3:0] digit_an;
    logic       frame_tick;

    logic       en3 = 1'b0;
    logic       wr_en3 = 1'b0;
    logic [1:0] wr_addr3 = '0;
    logic [3:0] wr_data3 = '0;
    logic [2:0] mask3 = '0;
    logic       lz3 = 1'b0;
    logic [3:0] bcd3;
    logic [2:0] an3;
    logic       tick3;

    int n_checks = 0;
    int n_err = 0;

    int         m_pos = 0;
    logic [3:0] m_regs [4] = '{default: 4'h0};
    logic [3:0] m_bcd = 4'h0;
    logic [3:0] m_an = 4'hF;
    logic       m_tick = 1'b0;
    exp_t       sb_q [$];

    seg_scan_ctrl #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blank_mask(blank_mask), .lz_en(lz_en),
        .bcd(bcd), .digit_an(digit_an), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(.DIGITS(3), .PRESCALE(2), .BLANK_CYCLES(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .blank_mask(mask3), .lz_en(lz3),
        .bcd(bcd3), .digit_an(an3), .frame_tick(tick3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: position inside the frame decides blank/show/capture
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pos = 0;
            m_regs = '{default: 4'h0};
            m_bcd = 4'h0;
            m_an = 4'hF;
            m_tick = 1'b0;
            sb_q.delete();
        end else begin
            if (!en) begin
                m_pos = 0;
                m_an = 4'hF;
                m_tick = 1'b0;
            end else begin
                int slot, ph;
                logic lzh;
                m_pos = (m_pos + 1) % FRAME;
                slot = m_pos / SLOT;
                ph = m_pos % SLOT;
                if (ph < BLNK) m_an = 4'hF;
                else if (ph == BLNK) begin
                    lzh = lz_en && slot > 0;
                    for (int j = slot; j < 4; j++) if (m_regs[j] != 4'h0) lzh = 1'b0;
                    m_bcd = m_regs[slot];
                    m_an = (blank_mask[slot] || lzh) ? 4'hF : ~(4'b0001 << slot);
                end
                m_tick = (m_pos == FRAME - 1);
            end
            if (wr_en) m_regs[wr_addr] = wr_data;
            sb_q.push_back('{m_an, m_bcd, m_tick});
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("digit_an", 32'(digit_an), 32'(e.an));
            check("bcd", 32'(bcd), 32'(e.bcd));
            check("frame_tick", 32'(frame_tick), 32'(e.tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 40 && m_pos != p; i++) @(negedge clk);
        check("sync_pos", 32'(m_pos), 32'(p));
    endtask

    task automatic wr3(input logic [1:0] a, input logic [3:0] d);
        wr_en3 = 1'b1;
        wr_addr3 = a;
        wr_data3 = d;
        @(negedge clk);
        wr_en3 = 1'b0;
    endtask

    initial begin
        logic [3:0] vals3 [3];
        vals3 = '{4'h7, 4'h8, 4'h9};
        cyc(2);
        rst_n = 1'b1;
        en = 1'b1;
        cyc(4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", 32'(digit_an), 32'hF);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        en = 1'b0;
        wr(2'd0, 4'd1);
        wr(2'd1, 4'd2);
        wr(2'd2, 4'd3);
        wr(2'd3, 4'd4);
        en = 1'b1;
        cyc(50);
        wait_pos(9);
        wr(2'd1, 4'd9);
        cyc(30);
        wr(2'd0, 4'd0);
        wr(2'd1, 4'd5);
        wr(2'd2, 4'd0);
        wr(2'd3, 4'd0);
        lz_en = 1'b1;
        cyc(26);
        wr(2'd1, 4'd0);
        cyc(26);
        lz_en = 1'b0;
        wr(2'd0, 4'd1);
        wr(2'd1, 4'd2);
        wr(2'd2, 4'd3);
        wr(2'd3, 4'd4);
        blank_mask = 4'b0100;
        cyc(26);
        wait_pos(15);
        blank_mask = 4'b0000;
        cyc(30);
        wait_pos(15);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(10);
        // three-digit instance: writes above the last digit must be dropped
        for (int i = 0; i < 3; i++) wr3(2'(i), vals3[i]);
        wr3(2'd3, 4'd0);
        en3 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            int p;
            @(negedge clk);
            p = k % 9;
            check("d3_an", 32'(an3), (p % 3 == 0) ? 32'h7 : 32'(~(3'b001 << (p / 3)) & 3'h7));
            if (p % 3 != 0) check("d3_bcd", 32'(bcd3), 32'(vals3[p / 3]));
            check("d3_tick", 32'(tick3), 32'(p == 8));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
